hpi_responder: RTL and testbench



---
 rtl/hpi_pkg.sv | 20 ++
 rtl/hpi_ram.sv | 21 ++
 rtl/hpi_responder.sv | 201 ++++++++++++++++++++
 tb/tb_hpi_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// rtl/hpi_pkg.sv - shared register map, FSM states and STATUS bit positions for the HPI responder
package hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int ST_OUT_VALID = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_OVF       = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_FETCH,
        S_RD_HOLD
    } hpi_state_e;

endpackage

// File: rtl/hpi_ram.sv
// rtl/hpi_ram.sv - single-port 2^AW x 16 synchronous RAM with one-cycle read
module hpi_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hpi_responder.sv
// rtl/hpi_responder.sv - HPI bus responder with DATA/MAILBOX/ADDRESS/STATUS registers and word RAM
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic        hpi_reset_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_int,
    output logic [15:0] mbx_out_data,
    output logic        mbx_out_valid,
    input  logic        mbx_out_ready,
    input  logic [15:0] mbx_in_data,
    input  logic        mbx_in_valid,
    output logic        mbx_in_ready
);

    hpi_state_e  state_q, state_d;
    logic        act_q, act_d, act_prev_q, act_prev_d;
    logic        rd_q, rd_d, wr_first_q, wr_first_d;
    logic [1:0]  hsel_q, hsel_d, sel_q, sel_d;
    logic [15:0] din_q, din_d, addr_q, addr_d, dout_q, dout_d;
    logic [15:0] mbx_out_data_q, mbx_out_data_d, mbx_in_reg_q, mbx_in_reg_d;
    logic        mbx_out_valid_q, mbx_out_valid_d, mbx_in_full_q, mbx_in_full_d;
    logic        ovf_q, ovf_d;
    logic        act, start, ram_we;
    logic [15:0] ram_rdata, status;

    assign act   = !hpi_cs_n && ((!hpi_r_n) ^ (!hpi_w_n));
    assign start = act_q && !act_prev_q;

    hpi_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[AW:1]),
        .wdata (din_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        status               = '0;
        status[ST_OUT_VALID] = mbx_out_valid_q;
        status[ST_IN_FULL]   = mbx_in_full_q;
        status[ST_OVF]       = ovf_q;
    end

    always_comb begin
        state_d         = state_q;
        act_d           = act;
        act_prev_d      = act_q;
        rd_d            = !hpi_r_n;
        hsel_d          = hpi_address;
        din_d           = hpi_data_in;
        sel_d           = sel_q;
        wr_first_d      = wr_first_q;
        addr_d          = addr_q;
        dout_d          = dout_q;
        mbx_out_data_d  = mbx_out_data_q;
        mbx_out_valid_d = mbx_out_valid_q;
        mbx_in_reg_d    = mbx_in_reg_q;
        mbx_in_full_d   = mbx_in_full_q;
        ovf_d           = ovf_q;
        ram_we          = 1'b0;

        if (mbx_out_valid_q && mbx_out_ready) begin
            mbx_out_valid_d = 1'b0;
        end
        if (mbx_in_valid && !mbx_in_full_q) begin
            mbx_in_reg_d  = mbx_in_data;
            mbx_in_full_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d = hsel_q;
                    if (rd_q) begin
                        state_d = S_RD_FETCH;
                    end else begin
                        state_d    = S_WR;
                        wr_first_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (wr_first_q) begin
                    wr_first_d = 1'b0;
                    unique case (sel_q)
                        HPI_DATA: begin
                            ram_we = 1'b1;
                            addr_d = addr_q + 16'd2;
                        end
                        HPI_MAILBOX: begin
                            // a same-cycle device consume makes room, so it is not an overflow
                            if (mbx_out_valid_q && !mbx_out_ready) begin
                                ovf_d = 1'b1;
                            end
                            mbx_out_data_d  = din_q;
                            mbx_out_valid_d = 1'b1;
                        end
                        HPI_ADDRESS: addr_d = din_q;
                        default: begin
                            if (din_q[ST_OVF]) begin
                                ovf_d = 1'b0;
                            end
                        end
                    endcase
                end
                if (!act_q) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_FETCH: begin
                unique case (sel_q)
                    HPI_DATA:    dout_d = ram_rdata;
                    HPI_MAILBOX: dout_d = mbx_in_reg_q;
                    HPI_ADDRESS: dout_d = addr_q;
                    default:     dout_d = status;
                endcase
                state_d = S_RD_HOLD;
            end
            default: begin
                if (!act_q) begin
                    state_d = S_IDLE;
                    if (sel_q == HPI_DATA) begin
                        addr_d = addr_q + 16'd2;
                    end else if (sel_q == HPI_MAILBOX) begin
                        mbx_in_full_d = 1'b0;
                    end
                end
            end
        endcase

        if (!hpi_reset_n) begin
            state_d         = S_IDLE;
            act_d           = 1'b1;
            act_prev_d      = 1'b1;
            wr_first_d      = 1'b0;
            sel_d           = HPI_DATA;
            addr_d          = '0;
            dout_d          = '0;
            mbx_out_data_d  = '0;
            mbx_out_valid_d = 1'b0;
            mbx_in_reg_d    = '0;
            mbx_in_full_d   = 1'b0;
            ovf_d           = 1'b0;
            ram_we          = 1'b0;
        end
    end

    // act history resets high so a strobe still held across reset is not seen as a new access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            act_q           <= 1'b1;
            act_prev_q      <= 1'b1;
            rd_q            <= 1'b0;
            hsel_q          <= HPI_DATA;
            din_q           <= '0;
            sel_q           <= HPI_DATA;
            wr_first_q      <= 1'b0;
            addr_q          <= '0;
            dout_q          <= '0;
            mbx_out_data_q  <= '0;
            mbx_out_valid_q <= 1'b0;
            mbx_in_reg_q    <= '0;
            mbx_in_full_q   <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            act_q           <= act_d;
            act_prev_q      <= act_prev_d;
            rd_q            <= rd_d;
            hsel_q          <= hsel_d;
            din_q           <= din_d;
            sel_q           <= sel_d;
            wr_first_q      <= wr_first_d;
            addr_q          <= addr_d;
            dout_q          <= dout_d;
            mbx_out_data_q  <= mbx_out_data_d;
            mbx_out_valid_q <= mbx_out_valid_d;
            mbx_in_reg_q    <= mbx_in_reg_d;
            mbx_in_full_q   <= mbx_in_full_d;
            ovf_q           <= ovf_d;
        end
    end

    assign hpi_data_out  = dout_q;
    assign hpi_int       = mbx_in_full_q;
    assign mbx_out_data  = mbx_out_data_q;
    assign mbx_out_valid = mbx_out_valid_q;
    assign mbx_in_ready  = !mbx_in_full_q;

endmodule

// File: tb/tb_hpi_responder.sv
// tb/tb_hpi_responder.sv - randomized self-checking bench for hpi_responder with a register-level model
module tb_hpi_responder;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  hpi_address = 2'd0;
    logic        hpi_cs_n = 1'b1, hpi_r_n = 1'b1, hpi_w_n = 1'b1, hpi_reset_n = 1'b1;
    logic [15:0] hpi_data_in = '0;
    logic [15:0] hpi_data_out;
    logic        hpi_int;
    logic [15:0] mbx_out_data;
    logic        mbx_out_valid;
    logic        mbx_out_ready = 1'b0;
    logic [15:0] mbx_in_data = '0;
    logic        mbx_in_valid = 1'b0;
    logic        mbx_in_ready;

    hpi_responder #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .hpi_address(hpi_address), .hpi_cs_n(hpi_cs_n),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n),
        .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_int(hpi_int),
        .mbx_out_data(mbx_out_data), .mbx_out_valid(mbx_out_valid), .mbx_out_ready(mbx_out_ready),
        .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid), .mbx_in_ready(mbx_in_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [WORDS];
    logic [15:0] m_addr, m_out_data, m_in_reg, m_dout;
    bit          m_out_valid, m_in_full, m_ovf;
    logic [15:0] saved;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a >> 1) % WORDS;
    endfunction

    task automatic model_reset();
        m_addr = 0; m_out_data = 0; m_in_reg = 0; m_dout = 0;
        m_out_valid = 0; m_in_full = 0; m_ovf = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".dout"}, hpi_data_out, m_dout);
        chk({tag, ".int"}, {15'd0, hpi_int}, {15'd0, m_in_full});
        chk({tag, ".out_valid"}, {15'd0, mbx_out_valid}, {15'd0, m_out_valid});
        chk({tag, ".out_data"}, mbx_out_data, m_out_data);
        chk({tag, ".in_ready"}, {15'd0, mbx_in_ready}, {15'd0, !m_in_full});
    endtask

    task automatic strobe(input bit rd, input logic [1:0] a, input logic [15:0] d);
        hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0;
        if (rd) hpi_r_n = 1'b0; else hpi_w_n = 1'b0;
    endtask

    task automatic release_bus();
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d, input string tag);
        strobe(1'b0, a, d);
        repeat (3) tick();
        release_bus();
        repeat (3) tick();
        case (a)
            2'd0: begin mem[widx(m_addr)] = d; m_addr += 16'd2; end
            2'd1: begin if (m_out_valid) m_ovf = 1; m_out_data = d; m_out_valid = 1; end
            2'd2: m_addr = d;
            default: if (d[2]) m_ovf = 0;
        endcase
        check_outs(tag);
    endtask

    task automatic host_read(input logic [1:0] a, input string tag);
        case (a)
            2'd0: begin m_dout = mem[widx(m_addr)]; m_addr += 16'd2; end
            2'd1: begin m_dout = m_in_reg; m_in_full = 0; end
            2'd2: m_dout = m_addr;
            default: m_dout = {13'd0, m_ovf, m_in_full, m_out_valid};
        endcase
        strobe(1'b1, a, 16'h0000);
        repeat (3) tick();
        release_bus();
        repeat (3) tick();
        check_outs(tag);
    endtask

    task automatic dev_offer(input logic [15:0] d);
        mbx_in_data = d; mbx_in_valid = 1'b1;
        tick();
        mbx_in_valid = 1'b0;
        if (!m_in_full) begin m_in_reg = d; m_in_full = 1; end
        tick();
        check_outs("offer");
    endtask

    task automatic dev_consume();
        mbx_out_ready = 1'b1;
        tick();
        mbx_out_ready = 1'b0;
        m_out_valid = 0;
        tick();
        check_outs("consume");
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        check_outs("reset");
        reset = 1'b0;
        repeat (2) tick();

        // fill the whole RAM so every later read has a known expectation
        host_write(2'd2, 16'h0000, "fill.addr");
        for (int i = 0; i < WORDS; i++) host_write(2'd0, 16'($urandom), "fill");
        host_read(2'd2, "fill.end_addr");
        chk("fill.end_addr_lit", hpi_data_out, 16'h0800);

        host_write(2'd2, 16'h0100, "tp1.a");
        host_write(2'd0, 16'hA5A5, "tp1.w0");
        host_write(2'd0, 16'h5A5A, "tp1.w1");
        host_write(2'd2, 16'h0100, "tp1.a2");
        host_read(2'd0, "tp1.r0");
        chk("tp1.r0_lit", hpi_data_out, 16'hA5A5);
        host_read(2'd0, "tp1.r1");
        chk("tp1.r1_lit", hpi_data_out, 16'h5A5A);
        host_read(2'd2, "tp1.ra");
        chk("tp1.ra_lit", hpi_data_out, 16'h0104);

        host_write(2'd2, 16'hFFFE, "wrap.a");
        host_write(2'd0, 16'h1234, "wrap.w");
        host_read(2'd2, "wrap.ra");
        chk("wrap.ra_lit", hpi_data_out, 16'h0000);
        host_write(2'd2, 16'h07FE, "alias.a");
        host_read(2'd0, "alias.r");
        chk("alias.r_lit", hpi_data_out, 16'h1234);

        host_write(2'd1, 16'hBEEF, "mbx.w0");
        chk("mbx.valid_lit", {15'd0, mbx_out_valid}, 16'h0001);
        host_read(2'd3, "mbx.st0");
        chk("mbx.st0_lit", hpi_data_out, 16'h0001);
        host_write(2'd1, 16'hCAFE, "mbx.w1");
        host_read(2'd3, "mbx.st1");
        chk("mbx.st1_lit", hpi_data_out, 16'h0005);
        chk("mbx.data_lit", mbx_out_data, 16'hCAFE);
        host_write(2'd3, 16'h0004, "mbx.clr");
        host_read(2'd3, "mbx.st2");
        chk("mbx.st2_lit", hpi_data_out, 16'h0001);
        dev_consume();

        dev_offer(16'h1357);
        chk("in.int_lit", {15'd0, hpi_int}, 16'h0001);
        dev_offer(16'h2468);
        host_read(2'd3, "in.st");
        chk("in.st_lit", hpi_data_out, 16'h0002);
        host_read(2'd1, "in.r");
        chk("in.r_lit", hpi_data_out, 16'h1357);
        chk("in.ready_lit", {15'd0, mbx_in_ready}, 16'h0001);

        // async reset while the read sits in its hold phase, strobe kept low across release
        host_write(2'd1, 16'h7777, "rrd.mbx");
        host_write(2'd2, 16'h0040, "rrd.a");
        strobe(1'b1, 2'd0, 16'h0000);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("rrd.in_reset");
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        release_bus();
        repeat (3) tick();
        check_outs("rrd.after");
        host_read(2'd2, "rrd.addr");
        chk("rrd.addr_lit", hpi_data_out, 16'h0000);

        // soft reset lands on the commit edge of a DATA write
        host_write(2'd2, 16'h0080, "rwr.a");
        saved = mem[widx(16'h0080)];
        strobe(1'b0, 2'd0, 16'hDEAD);
        repeat (2) tick();
        hpi_reset_n = 1'b0;
        tick();
        model_reset();
        check_outs("rwr.in_reset");
        tick();
        hpi_reset_n = 1'b1;
        repeat (3) tick();
        release_bus();
        repeat (3) tick();
        host_read(2'd2, "rwr.addr");
        host_write(2'd2, 16'h0080, "rwr.a2");
        host_read(2'd0, "rwr.data");
        chk("rwr.data_kept", hpi_data_out, saved);

        // both strobes low, then strobes with chip select high: nothing may change
        host_write(2'd2, 16'h0200, "ill.a");
        hpi_address = 2'd0; hpi_data_in = 16'hFACE; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        repeat (4) tick();
        release_bus();
        repeat (3) tick();
        hpi_address = 2'd2; hpi_data_in = 16'h3333; hpi_w_n = 1'b0;
        repeat (4) tick();
        release_bus();
        hpi_address = 2'd1; hpi_w_n = 1'b0;
        repeat (4) tick();
        release_bus();
        hpi_r_n = 1'b0; hpi_address = 2'd0;
        repeat (4) tick();
        release_bus();
        repeat (3) tick();
        check_outs("ill.outs");
        host_read(2'd2, "ill.addr");
        chk("ill.addr_lit", hpi_data_out, 16'h0200);
        host_read(2'd0, "ill.data");
        host_read(2'd3, "ill.status");

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: host_write(2'($urandom_range(0, 3)), 16'($urandom), "rnd.w");
                1, 2: host_read(2'($urandom_range(0, 3)), "rnd.r");
                3: dev_offer(16'($urandom));
                4: dev_consume();
                default: host_write(2'd1, 16'($urandom), "rnd.mbx");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
